irq_pending_ctrl: RTL and testbench

IRQ_PENDING_CTRL -- requirements
Module: irq_pending_ctrl

---
 rtl/irq_pkg.sv | 6 +
 rtl/priority_encoder_16x4.sv | 13 +
 rtl/irq_pending_ctrl.sv | 81 ++++++++
 tb/tb_irq_pending_ctrl.sv | 175 +++++++++++++++++
 4 files changed

// File: rtl/irq_pkg.sv
// irq_pkg: shared sizes and FSM state encoding for irq_pending_ctrl.
package irq_pkg;
    localparam int NUM_IRQ = 16;
    localparam int ID_W    = 4;
    typedef enum logic [1:0] {IDLE, PRESENT, GAP} state_e;
endpackage

// File: rtl/priority_encoder_16x4.sv
// priority_encoder_16x4: index of the highest set bit; output is only meaningful for nonzero input.
module priority_encoder_16x4
    import irq_pkg::*;
(
    input  logic [NUM_IRQ-1:0] d_i,
    output logic [ID_W-1:0]    y_o
);
    always_comb begin
        y_o = '0;
        for (int i = 0; i < NUM_IRQ; i++)
            if (d_i[i]) y_o = ID_W'(i);
    end
endmodule

// File: rtl/irq_pending_ctrl.sv
// irq_pending_ctrl: latches interrupt requests and presents the highest enabled one until acknowledged.
// Define IRQ_EDGE_EN for rising-edge capture; the default build captures request levels.
module irq_pending_ctrl
    import irq_pkg::*;
#(
    parameter int ACK_GAP = 1
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic [NUM_IRQ-1:0] req,
    input  logic [NUM_IRQ-1:0] mask,
    input  logic               irq_ack,
    output logic               irq_valid,
    output logic [ID_W-1:0]    irq_id,
    output logic [NUM_IRQ-1:0] pending
);
    state_e             state_q, state_d;
    logic [NUM_IRQ-1:0] pending_q, pending_d;
    logic [ID_W-1:0]    id_q, id_d;
    logic [1:0]         gap_q, gap_d;
    logic [NUM_IRQ-1:0] eligible, capture, clr;
    logic [ID_W-1:0]    winner;
    logic               gap_done;

`ifdef IRQ_EDGE_EN
    logic [NUM_IRQ-1:0] req_q;
    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) req_q <= '0;
        else        req_q <= req;
    assign capture = req & ~req_q;
`else
    assign capture = req;
`endif

    assign eligible = pending_q & mask;

    priority_encoder_16x4 u_enc (
        .d_i(eligible),
        .y_o(winner)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            pending_q <= '0;
            id_q      <= '0;
            gap_q     <= '0;
        end else begin
            state_q   <= state_d;
            pending_q <= pending_d;
            id_q      <= id_d;
            gap_q     <= gap_d;
        end
    end

    assign gap_done = int'(gap_q) == ACK_GAP - 1;

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (|eligible) state_d = PRESENT;
            PRESENT: if (irq_ack) state_d = (ACK_GAP > 0) ? GAP : IDLE;
            GAP:     if (gap_done) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Set is OR-ed in after the clear so a same-cycle request re-pends the bit.
    always_comb begin
        clr       = (state_q == PRESENT && irq_ack) ? NUM_IRQ'(1) << id_q : '0;
        pending_d = (pending_q & ~clr) | capture;
        gap_d     = (state_q == GAP) ? gap_q + 2'd1 : 2'd0;
        id_d      = (state_d != PRESENT) ? '0 : (state_q == PRESENT) ? id_q : winner;
    end

    always_comb begin
        irq_valid = state_q == PRESENT;
        irq_id    = id_q;
        pending   = pending_q;
    end
endmodule

// File: tb/tb_irq_pending_ctrl.sv
// tb_irq_pending_ctrl: vector table, corner sequences and randomized run against a reference model.
module tb_irq_pending_ctrl;
    import irq_pkg::*;

`ifdef IRQ_EDGE_EN
    localparam bit EDGE = 1'b1;
`else
    localparam bit EDGE = 1'b0;
`endif
    localparam int GAP_N = 1;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [15:0] req, mask, req0, mask0;
    logic        irq_ack, ack0;
    logic        irq_valid, valid0;
    logic [3:0]  irq_id, id0;
    logic [15:0] pending, pending0;

    int n_cmp = 0;
    int n_bad = 0;

    irq_pending_ctrl #(.ACK_GAP(GAP_N)) dut (
        .clk(clk), .rst_n(rst_n), .req(req), .mask(mask), .irq_ack(irq_ack),
        .irq_valid(irq_valid), .irq_id(irq_id), .pending(pending)
    );

    irq_pending_ctrl #(.ACK_GAP(0)) dut0 (
        .clk(clk), .rst_n(rst_n), .req(req0), .mask(mask0), .irq_ack(ack0),
        .irq_valid(valid0), .irq_id(id0), .pending(pending0)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [15:0] req;
        logic [15:0] mask;
        logic        ack;
        logic        v;
        logic [3:0]  id;
        logic [15:0] p;
    } vec_t;

    vec_t tbl[$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic do_reset();
        rst_n = 1'b0; req = '0; mask = 16'hFFFF; irq_ack = 1'b0;
        req0 = '0; mask0 = 16'hFFFF; ack0 = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    function automatic int highest(input logic [15:0] v);
        int r = -1;
        for (int i = 0; i < 16; i++) if (v[i]) r = i;
        return r;
    endfunction

    logic [15:0] m_p, m_prev, m_cap, m_clr;
    int          m_id, m_wait, nid;

    initial begin
        do_reset();
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            chk("idle_valid", irq_valid, 1'b0);
            chk("idle_pending", pending, 16'h0);
        end
        // {req, mask, ack} applied before an edge, {valid, id, pending} expected after it
        tbl.push_back('{16'h0021, 16'hFFFF, 1'b0, 1'b0, 4'd0,  16'h0021});
        tbl.push_back('{16'h0000, 16'hFFFF, 1'b0, 1'b1, 4'd5,  16'h0021});
        tbl.push_back('{16'h0000, 16'hFFFF, 1'b0, 1'b1, 4'd5,  16'h0021});
        tbl.push_back('{16'h0000, 16'hFFFF, 1'b1, 1'b0, 4'd0,  16'h0001});
        tbl.push_back('{16'h0000, 16'hFFFF, 1'b1, 1'b0, 4'd0,  16'h0001});
        tbl.push_back('{16'h0000, 16'hFFFF, 1'b0, 1'b1, 4'd0,  16'h0001});
        tbl.push_back('{16'h0000, 16'hFFFF, 1'b1, 1'b0, 4'd0,  16'h0000});
        tbl.push_back('{16'h0000, 16'hFFFF, 1'b0, 1'b0, 4'd0,  16'h0000});
        tbl.push_back('{16'h8001, 16'h7FFF, 1'b0, 1'b0, 4'd0,  16'h8001});
        tbl.push_back('{16'h0000, 16'h7FFF, 1'b0, 1'b1, 4'd0,  16'h8001});
        tbl.push_back('{16'h0000, 16'hFFFF, 1'b0, 1'b1, 4'd0,  16'h8001});
        tbl.push_back('{16'h0000, 16'hFFFF, 1'b1, 1'b0, 4'd0,  16'h8000});
        tbl.push_back('{16'h0000, 16'hFFFF, 1'b0, 1'b0, 4'd0,  16'h8000});
        tbl.push_back('{16'h0000, 16'hFFFF, 1'b0, 1'b1, 4'd15, 16'h8000});
        tbl.push_back('{16'h0000, 16'hFFFF, 1'b1, 1'b0, 4'd0,  16'h0000});
        tbl.push_back('{16'h0000, 16'hFFFF, 1'b0, 1'b0, 4'd0,  16'h0000});
        tbl.push_back('{16'h0010, 16'hFFFF, 1'b0, 1'b0, 4'd0,  16'h0010});
        tbl.push_back('{16'h0000, 16'hFFFF, 1'b0, 1'b1, 4'd4,  16'h0010});
        tbl.push_back('{16'h0010, 16'hFFFF, 1'b1, 1'b0, 4'd0,  16'h0010});
        tbl.push_back('{16'h0000, 16'hFFFF, 1'b0, 1'b0, 4'd0,  16'h0010});
        tbl.push_back('{16'h0000, 16'hFFFF, 1'b0, 1'b1, 4'd4,  16'h0010});
        tbl.push_back('{16'h0000, 16'hFFFF, 1'b1, 1'b0, 4'd0,  16'h0000});
        tbl.push_back('{16'h0000, 16'hFFFF, 1'b0, 1'b0, 4'd0,  16'h0000});
        foreach (tbl[i]) begin
            req = tbl[i].req; mask = tbl[i].mask; irq_ack = tbl[i].ack;
            @(negedge clk);
            chk($sformatf("tbl%0d_valid", i), irq_valid, tbl[i].v);
            chk($sformatf("tbl%0d_id", i), irq_id, tbl[i].id);
            chk($sformatf("tbl%0d_pending", i), pending, tbl[i].p);
        end

        // held request: level mode re-pends after ack, edge mode does not
        req = 16'h0008; irq_ack = 1'b0;
        @(negedge clk); chk("hold_pend", pending, 16'h0008);
        @(negedge clk); chk("hold_id", irq_id, 4'd3); chk("hold_valid", irq_valid, 1'b1);
        irq_ack = 1'b1;
        @(negedge clk); chk("hold_ack_pend", pending, EDGE ? 16'h0000 : 16'h0008);
        irq_ack = 1'b0;
        @(negedge clk); chk("hold_gap_valid", irq_valid, 1'b0);
        @(negedge clk); chk("hold_re_valid", irq_valid, !EDGE);
        chk("hold_re_id", irq_id, EDGE ? 4'd0 : 4'd3);
        req = '0; irq_ack = 1'b1;
        @(negedge clk); irq_ack = 1'b0;
        repeat (3) @(negedge clk);
        chk("hold_end_valid", irq_valid, 1'b0); chk("hold_end_pend", pending, 16'h0);

        // asynchronous reset while presenting id 9
        req = 16'h0200;
        @(negedge clk); req = '0;
        @(negedge clk); chk("rst_pre_id", irq_id, 4'd9); chk("rst_pre_valid", irq_valid, 1'b1);
        #2 rst_n = 1'b0;
        #1 chk("rst_valid", irq_valid, 1'b0); chk("rst_pend", pending, 16'h0); chk("rst_id", irq_id, 4'd0);
        @(negedge clk); rst_n = 1'b1;
        repeat (3) begin
            @(negedge clk);
            chk("post_rst_valid", irq_valid, 1'b0); chk("post_rst_id", irq_id, 4'd0);
            chk("post_rst_pend", pending, 16'h0);
        end

        // ACK_GAP=0 with ack held high
        req0 = 16'h0006; ack0 = 1'b1;
        @(negedge clk); req0 = '0; chk("g0_pend", pending0, 16'h0006); chk("g0_v0", valid0, 1'b0);
        @(negedge clk); chk("g0_v1", valid0, 1'b1); chk("g0_id2", id0, 4'd2);
        @(negedge clk); chk("g0_idle", valid0, 1'b0); chk("g0_pend2", pending0, 16'h0002);
        @(negedge clk); chk("g0_v2", valid0, 1'b1); chk("g0_id1", id0, 4'd1);
        @(negedge clk); chk("g0_end", valid0, 1'b0); chk("g0_pend0", pending0, 16'h0);
        ack0 = 1'b0;

        // randomized run against the reference model
        do_reset();
        m_p = '0; m_prev = '0; m_id = -1; m_wait = 0;
        for (int c = 0; c < 400; c++) begin
            chk("rnd_valid", irq_valid, m_id >= 0);
            chk("rnd_id", irq_id, (m_id >= 0) ? 4'(m_id) : 4'd0);
            chk("rnd_pending", pending, m_p);
            req = 16'($urandom & $urandom & $urandom);
            mask = 16'($urandom | $urandom);
            irq_ack = ($urandom_range(0, 2) == 0);
            m_cap = EDGE ? (req & ~m_prev) : req;
            m_clr = '0;
            nid = m_id;
            if (m_id >= 0) begin
                if (irq_ack) begin
                    m_clr[m_id] = 1'b1; nid = -1; m_wait = GAP_N;
                end
            end else if (m_wait > 0) m_wait--;
            else if ((m_p & mask) != 0) nid = highest(m_p & mask);
            m_p = (m_p & ~m_clr) | m_cap;
            m_id = nid;
            m_prev = req;
            @(negedge clk);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
